// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and index helper for the 8x8/3x3/6x6 convolution blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    localparam int IMG_DIM = 8;
    localparam int KER_DIM = 3;
    localparam int OUT_DIM = 6;

    // Common to the forward and backward blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // Row-major flattened index of element [row][col] in a dim-wide square array.
    function automatic int flat_idx(input int row, input int col, input int dim);
        return row * dim + col;
    endfunction

endpackage

// File: rtl/conv_sat_trunc.sv
// Signed width adapter: sign-extends when widening, saturates to the signed range when narrowing.
// Latency: combinational.
// Backpressure: none.
// Ports: din (IN_W signed) -> dout (OUT_W signed).
module conv_sat_trunc #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 20
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    generate
        if (OUT_W == IN_W) begin : g_pass
            assign dout = din;
        end else if (OUT_W > IN_W) begin : g_extend
            assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
        end else begin : g_sat
            // Largest and smallest OUT_W-bit values, expressed at IN_W for comparison.
            logic signed [IN_W-1:0] max_v;
            logic signed [IN_W-1:0] min_v;
            assign max_v = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            assign min_v = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

            always_comb begin
                dout = din[OUT_W-1:0];
                if (din > max_v) begin
                    dout = max_v[OUT_W-1:0];
                end else if (din < min_v) begin
                    dout = min_v[OUT_W-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/conv_backprop_input.sv
// Input-gradient (full/transposed) convolution: dX[8x8] from dY[6x6] and K[3x3], one MAC tap per cycle.
// Latency: done pulses 576 cycles after the start-accept edge (64 pixels x 9 taps).
// Backpressure: none; start is only accepted in IDLE, ignored while busy or in DONE.
// Ports: clk, reset (sync, active-high), start, grad_in (36 x DATA_WIDTH_GRAD), kernel (9 x DATA_WIDTH_KERNEL)
//        -> busy, done (one-cycle pulse), out (64 x DATA_WIDTH_OUT, valid from the done cycle).
module conv_backprop_input
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH_GRAD   = 12,
    parameter int DATA_WIDTH_KERNEL = 4,
    parameter int DATA_WIDTH_OUT    = 20
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [DATA_WIDTH_GRAD*OUT_DIM*OUT_DIM-1:0] grad_in,
    input  logic [DATA_WIDTH_KERNEL*KER_DIM*KER_DIM-1:0] kernel,
    output logic                                   busy,
    output logic                                   done,
    output logic [DATA_WIDTH_OUT*IMG_DIM*IMG_DIM-1:0] out
);

    localparam int PROD_W   = DATA_WIDTH_GRAD + DATA_WIDTH_KERNEL;
    localparam int ACC_W    = PROD_W + 4;
    localparam int LAST_PIX = IMG_DIM * IMG_DIM - 1;
    localparam int LAST_TAP = KER_DIM * KER_DIM - 1;

    conv_state_t state;
    logic [5:0]  p;
    logic [3:0]  t;
    logic signed [ACC_W-1:0] acc;

    logic [DATA_WIDTH_GRAD*OUT_DIM*OUT_DIM-1:0]   g_q;
    logic [DATA_WIDTH_KERNEL*KER_DIM*KER_DIM-1:0] k_q;

    // Tap addressing: (r,c) output pixel, (i,j) kernel tap, dY[r-i][c-j] source.
    int   ti, tj, rr, cc, g_idx, k_idx;
    logic tap_ok;

    always_comb begin
        ti     = int'(t) / KER_DIM;
        tj     = int'(t) % KER_DIM;
        rr     = int'(p[5:3]) - ti;
        cc     = int'(p[2:0]) - tj;
        tap_ok = (rr >= 0) && (rr < OUT_DIM) && (cc >= 0) && (cc < OUT_DIM);
        // Out-of-range taps still take their slot; point at element 0 and mask the product.
        g_idx  = tap_ok ? flat_idx(rr, cc, OUT_DIM) : 0;
        k_idx  = flat_idx(ti, tj, KER_DIM);
    end

    logic signed [DATA_WIDTH_GRAD-1:0]   g_val;
    logic signed [DATA_WIDTH_KERNEL-1:0] k_val;
    logic signed [PROD_W-1:0]            prod;
    logic signed [ACC_W-1:0]             term;
    logic signed [ACC_W-1:0]             acc_next;
    logic signed [DATA_WIDTH_OUT-1:0]    sat_val;

    assign g_val    = $signed(g_q[g_idx*DATA_WIDTH_GRAD +: DATA_WIDTH_GRAD]);
    assign k_val    = $signed(k_q[k_idx*DATA_WIDTH_KERNEL +: DATA_WIDTH_KERNEL]);
    assign prod     = g_val * k_val;
    assign term     = tap_ok ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : '0;
    assign acc_next = acc + term;

    conv_sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH_OUT)
    ) u_sat (
        .din  (acc_next),
        .dout (sat_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            acc   <= '0;
            p     <= '0;
            t     <= '0;
            g_q   <= '0;
            k_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        g_q   <= grad_in;
                        k_q   <= kernel;
                        p     <= '0;
                        t     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (t == 4'(LAST_TAP)) begin
                        // Final tap folds straight into the writeback; the accumulator restarts.
                        out[p*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] <= sat_val;
                        acc <= '0;
                        t   <= '0;
                        p   <= p + 6'd1;
                        if (p == 6'(LAST_PIX)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        acc <= acc_next;
                        t   <= t + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_backprop_input.sv
// Bench for conv_backprop_input: default-width and 16-bit-output instances driven in parallel,
// checked against a direct sum-of-products reference of the input-gradient formula.
module tb_conv_backprop_input;

    localparam int GW   = 12;
    localparam int KW   = 4;
    localparam int OW   = 20;
    localparam int OWN  = 16;
    localparam int NPIX = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [GW*36-1:0]    grad_in;
    logic [KW*9-1:0]     kernel;
    logic                busy, done, busy_n, done_n;
    logic [OW*NPIX-1:0]  out;
    logic [OWN*NPIX-1:0] out_n;

    always #5 clk = ~clk;

    conv_backprop_input dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .grad_in (grad_in),
        .kernel  (kernel),
        .busy    (busy),
        .done    (done),
        .out     (out)
    );

    conv_backprop_input #(.DATA_WIDTH_OUT(OWN)) dut_n (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .grad_in (grad_in),
        .kernel  (kernel),
        .busy    (busy_n),
        .done    (done_n),
        .out     (out_n)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int g[36];
    int k[9];
    int exp_w[NPIX];
    int exp_n[NPIX];

    task automatic check(input string tag, input int got, input int expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int dx_w(input int idx);
        logic signed [OW-1:0] v;
        v = out[idx*OW +: OW];
        return int'(v);
    endfunction

    function automatic int dx_n(input int idx);
        logic signed [OWN-1:0] v;
        v = out_n[idx*OWN +: OWN];
        return int'(v);
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < 36; i++) grad_in[i*GW +: GW] = g[i][GW-1:0];
        for (int i = 0; i < 9; i++)  kernel[i*KW +: KW]  = k[i][KW-1:0];
    endtask

    // dX[r][c] = sum K[i][j] * dY[r-i][c-j], dropping taps that fall outside dY.
    task automatic model();
        int s;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (r - i >= 0 && r - i < 6 && c - j >= 0 && c - j < 6)
                            s += k[i*3+j] * g[(r-i)*6 + (c-j)];
                exp_w[r*8+c] = s;
                exp_n[r*8+c] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("%s_w[%0d]", tag, i), dx_w(i), exp_w[i]);
            check($sformatf("%s_n[%0d]", tag, i), dx_n(i), exp_n[i]);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // One full job: accept, 576-cycle latency, one-cycle done, outputs against the model.
    task automatic run_job(input string tag);
        int cycles;
        drive_ops();
        model();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy_hi"}, int'(busy), 1);
        wait_done(cycles);
        check({tag, "_latency"}, cycles, 576);
        check({tag, "_busy_lo"}, int'(busy), 0);
        check({tag, "_done_n"}, int'(done_n), 1);
        check_outputs(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    task automatic set_all(input int gv, input int kv);
        for (int i = 0; i < 36; i++) g[i] = gv;
        for (int i = 0; i < 9; i++)  k[i] = kv;
    endtask

    task automatic set_random();
        for (int i = 0; i < 36; i++) g[i] = int'($urandom_range(4095)) - 2048;
        for (int i = 0; i < 9; i++)  k[i] = int'($urandom_range(15)) - 8;
    endtask

    initial begin
        int cycles;
        int cnt;

        reset   = 1'b1;
        start   = 1'b0;
        grad_in = '0;
        kernel  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out",  int'(out != '0), 0);

        // 1: identity tap at K[0][0]
        set_all(0, 0);
        for (int i = 0; i < 36; i++) g[i] = i;
        k[0] = 1;
        run_job("t1");
        check("t1_55", dx_w(5*8+5), 35);
        check("t1_67", dx_w(6*8+7), 0);

        // 2: shifted tap at K[2][2]
        set_all(0, 0);
        for (int i = 0; i < 36; i++) g[i] = i;
        k[8] = 1;
        run_job("t2");
        check("t2_22", dx_w(2*8+2), 0);
        check("t2_77", dx_w(7*8+7), 35);

        // 3: all ones
        set_all(1, 1);
        run_job("t3");
        check("t3_00", dx_w(0), 1);
        check("t3_01", dx_w(1), 2);
        check("t3_11", dx_w(9), 4);
        check("t3_34", dx_w(3*8+4), 9);
        check("t3_77", dx_w(63), 1);

        // 4: extreme negative operands, saturation on the narrow instance
        set_all(-2048, -8);
        run_job("t4");
        check("t4_44_w", dx_w(4*8+4), 147456);
        check("t4_00_w", dx_w(0), 16384);
        check("t4_44_n", dx_n(4*8+4), 32767);
        check("t4_00_n", dx_n(0), 16384);

        // Random operand sets
        for (int n = 0; n < 3; n++) begin
            set_random();
            run_job($sformatf("rnd%0d", n));
        end

        // 5: reset in the middle of CALC
        set_random();
        drive_ops();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (299) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_out",  int'(out != '0), 0);
        check("t5_out_n", int'(out_n != '0), 0);
        cnt = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            cnt += int'(done);
        end
        check("t5_no_done", cnt, 0);
        set_all(1, 1);
        run_job("t5_rerun");
        check("t5_34", dx_w(3*8+4), 9);

        // 6: start held high; operands change right after accept
        set_random();
        drive_ops();
        model();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check("t6_busy", int'(busy), 1);
        set_random();
        drive_ops();
        wait_done(cycles);
        check("t6_latency", cycles, 576);
        check_outputs("t6a");
        model();
        @(negedge clk);
        check("t6_done_pulse", int'(done), 0);
        cycles = 1;
        while (!done && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        check("t6_period", cycles, 578);
        check_outputs("t6b");
        start = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cnt += int'(busy) + int'(done);
        end
        check("t6_no_retrigger", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
